// File: rtl/tile_writeback_sequencer_pkg.sv
// Shared frame/tile geometry, bus widths and sequencer state encoding for the tile writeback path.
package tile_writeback_sequencer_pkg;

  localparam int unsigned TILES_X_DEF   = 40;
  localparam int unsigned TILES_Y_DEF   = 30;
  localparam int unsigned TILE_ROWS_DEF = 16;
  localparam int unsigned PIX_W         = 8;
  localparam int unsigned ROW_PIX       = 16;
  localparam int unsigned ROW_W         = PIX_W * ROW_PIX;
  localparam int unsigned PAIR_W        = 2 * ROW_W;
  localparam int unsigned COORD_W       = 6;
  localparam int unsigned ROW_IDX_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL_LO = 3'd1,
    ST_FILL_HI = 3'd2,
    ST_EMIT    = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  typedef struct packed {
    logic [ROW_W-1:0] hi;
    logic [ROW_W-1:0] lo;
  } pair_t;

  function automatic logic [ROW_W-1:0] splat_pixel(input logic [PIX_W-1:0] pix);
    return {ROW_PIX{pix}};
  endfunction

endpackage

// File: rtl/tile_writeback_sequencer_tile_coord_counter.sv
// Row-pair / tile-x / tile-y raster counters; last_pair_o flags the final pair of the frame.
module tile_coord_counter
  import tile_writeback_sequencer_pkg::*;
#(
  parameter int unsigned TILES_X   = TILES_X_DEF,
  parameter int unsigned TILES_Y   = TILES_Y_DEF,
  parameter int unsigned TILE_ROWS = TILE_ROWS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr_i,
  input  logic                 advance_i,
  output logic [COORD_W-1:0]   tile_x_o,
  output logic [COORD_W-1:0]   tile_y_o,
  output logic [ROW_IDX_W-1:0] tile_row_o,
  output logic                 last_pair_o
);

  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(TILE_ROWS - 2);
  localparam logic [COORD_W-1:0]   X_LAST   = COORD_W'(TILES_X - 1);
  localparam logic [COORD_W-1:0]   Y_LAST   = COORD_W'(TILES_Y - 1);

  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic                 last_q, last_d;

  always_comb begin
    row_d = row_q;
    x_d   = x_q;
    y_d   = y_q;
    if (clr_i) begin
      row_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else if (advance_i) begin
      if (row_q == ROW_LAST) begin
        row_d = '0;
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
        end else begin
          x_d = x_q + COORD_W'(1);
        end
      end else begin
        row_d = row_q + ROW_IDX_W'(2);
      end
    end
    // Registered flag tracks the coordinates it will sit beside next cycle.
    last_d = (row_d == ROW_LAST) && (x_d == X_LAST) && (y_d == Y_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      last_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      x_q    <= x_d;
      y_q    <= y_d;
      last_q <= last_d;
    end
  end

  assign tile_x_o    = x_q;
  assign tile_y_o    = y_q;
  assign tile_row_o  = row_q;
  assign last_pair_o = last_q;

endmodule

// File: rtl/tile_writeback_sequencer.sv
// Packs shaded 16-pixel rows into 256-bit row pairs and strobes them out in tile raster order.
// Optional WB_CLEAR_EN adds a clear-frame mode that fills every pair with one color.
module tile_writeback_sequencer
  import tile_writeback_sequencer_pkg::*;
#(
  parameter int unsigned TILES_X   = TILES_X_DEF,
  parameter int unsigned TILES_Y   = TILES_Y_DEF,
  parameter int unsigned TILE_ROWS = TILE_ROWS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
`ifdef WB_CLEAR_EN
  input  logic                 i_clear_start,
  input  logic [PIX_W-1:0]     i_clear_color,
`endif
  input  logic                 i_frame_start,
  input  logic                 i_row_valid,
  input  logic [ROW_W-1:0]     i_row_data,
  output logic                 o_row_ready,
  output logic                 o_sm_render_done,
  output logic [COORD_W-1:0]   o_current_tile_x,
  output logic [COORD_W-1:0]   o_current_tile_y,
  output logic [ROW_IDX_W-1:0] o_tile_row,
  output logic [PAIR_W-1:0]    o_sm_color_data,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  state_e           state_q;
  pair_t            pair_q;
  logic             ready_q;
  logic             render_done_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             last_pair;
  logic             start_c;
  logic             fill_auto_c;
  logic             take_c;
  logic [ROW_W-1:0] fill_row_c;

`ifdef WB_CLEAR_EN
  logic             clear_mode_q;
  logic [PIX_W-1:0] clear_color_q;

  // Clear mode and its color are latched once per frame at start; frame_start has priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clear_mode_q  <= 1'b0;
      clear_color_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (i_frame_start) begin
        clear_mode_q <= 1'b0;
      end else if (i_clear_start) begin
        clear_mode_q  <= 1'b1;
        clear_color_q <= i_clear_color;
      end
    end
  end

  assign start_c     = i_frame_start | i_clear_start;
  assign fill_auto_c = clear_mode_q;
  assign fill_row_c  = clear_mode_q ? splat_pixel(clear_color_q) : i_row_data;
`else
  assign start_c     = i_frame_start;
  assign fill_auto_c = 1'b0;
  assign fill_row_c  = i_row_data;
`endif

  assign take_c = fill_auto_c | (i_row_valid & ready_q);

  tile_coord_counter #(
    .TILES_X   (TILES_X),
    .TILES_Y   (TILES_Y),
    .TILE_ROWS (TILE_ROWS)
  ) u_coord (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr_i       (state_q == ST_IDLE),
    .advance_i   (state_q == ST_GAP),
    .tile_x_o    (o_current_tile_x),
    .tile_y_o    (o_current_tile_y),
    .tile_row_o  (o_tile_row),
    .last_pair_o (last_pair)
  );

  // Sequencer FSM; pair data is only written in the fill states so it holds through EMIT and GAP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pair_q        <= '0;
      ready_q       <= 1'b0;
      render_done_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      render_done_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            state_q <= ST_FILL_LO;
            busy_q  <= 1'b1;
            ready_q <= i_frame_start;
          end
        end
        ST_FILL_LO: begin
          if (take_c) begin
            pair_q.lo <= fill_row_c;
            state_q   <= ST_FILL_HI;
          end
        end
        ST_FILL_HI: begin
          if (take_c) begin
            pair_q.hi     <= fill_row_c;
            ready_q       <= 1'b0;
            render_done_q <= 1'b1;
            state_q       <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          if (last_pair) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end else begin
            state_q <= ST_FILL_LO;
            ready_q <= ~fill_auto_c;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_row_ready      = ready_q;
  assign o_sm_render_done = render_done_q;
  assign o_sm_color_data  = pair_q;
  assign o_busy           = busy_q;
  assign o_frame_done     = frame_done_q;

endmodule

// File: tb/tb_tile_writeback_sequencer.sv
// Scoreboard bench: accepted row pairs are queued and matched against each render-done strobe.
module tb_tile_writeback_sequencer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         frame_start;
  logic         row_valid;
  logic [127:0] row_data;
  logic         row_ready;
  logic         render_done;
  logic [5:0]   tile_x;
  logic [5:0]   tile_y;
  logic [3:0]   tile_row;
  logic [255:0] color_data;
  logic         busy;
  logic         frame_done;
`ifdef WB_CLEAR_EN
  logic         clear_start;
  logic [7:0]   clear_color;
`endif

  always #5 clk = ~clk;

  tile_writeback_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
`ifdef WB_CLEAR_EN
    .i_clear_start    (clear_start),
    .i_clear_color    (clear_color),
`endif
    .i_frame_start    (frame_start),
    .i_row_valid      (row_valid),
    .i_row_data       (row_data),
    .o_row_ready      (row_ready),
    .o_sm_render_done (render_done),
    .o_current_tile_x (tile_x),
    .o_current_tile_y (tile_y),
    .o_tile_row       (tile_row),
    .o_sm_color_data  (color_data),
    .o_busy           (busy),
    .o_frame_done     (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [255:0] data_q[$];
  logic [127:0] lo_sb;
  bit           half;
  int           strobe_idx;
  int           last_strobe_cyc;
  int           first_strobe_cyc;
  int           frame_done_cnt;
  bit           hold_pending;
  logic [5:0]   snap_x, snap_y;
  logic [3:0]   snap_row;
  logic [255:0] snap_data;
  int           drive_mode = 2;
  bit           strict_period;
  bit           clear_run;
  bit           mon_en;
  logic [255:0] clear_pair;
  int           start_cyc;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_x(input int n);
    return 6'((n / 8) % 40);
  endfunction

  function automatic logic [5:0] exp_y(input int n);
    return 6'(n / 320);
  endfunction

  function automatic logic [3:0] exp_row(input int n);
    return 4'((n % 8) * 2);
  endfunction

  task automatic reset_model();
    data_q.delete();
    half             = 1'b0;
    strobe_idx       = 0;
    last_strobe_cyc  = 0;
    first_strobe_cyc = -1;
    frame_done_cnt   = 0;
    hold_pending     = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (strobe_idx < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (strobe_idx < n) check("strobe_timeout", 256'(strobe_idx), 256'(n));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (frame_done_cnt < 1 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (frame_done_cnt < 1) check("done_timeout", 256'(frame_done_cnt), 256'(1));
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 frame_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (drive_mode)
        0: begin
          row_valid = 1'b1;
          row_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        1: begin
          row_valid = 1'($urandom_range(0, 1));
          row_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        default: row_valid = 1'b0;
      endcase
    end
  end

  // Reference model: accepts, strobe contents, raster coords, hold cycle and frame-done.
  always @(negedge clk) begin : mon
    logic [255:0] exp_d;
    if (reset_n && mon_en) begin
      if (clear_run) check("clr_ready", 256'(row_ready), 256'(0));
      if (row_ready && row_valid) begin
        if (!half) begin
          lo_sb = row_data;
          half  = 1'b1;
        end else begin
          data_q.push_back({row_data, lo_sb});
          half = 1'b0;
        end
      end
      if (render_done) begin
        if (hold_pending) check("back_to_back", 256'(1), 256'(0));
        check("tile_x", 256'(tile_x), 256'(exp_x(strobe_idx)));
        check("tile_y", 256'(tile_y), 256'(exp_y(strobe_idx)));
        check("tile_row", 256'(tile_row), 256'(exp_row(strobe_idx)));
        if (clear_run) begin
          check("clr_data", color_data, clear_pair);
        end else if (data_q.size() == 0) begin
          check("sb_empty", 256'(1), 256'(0));
        end else begin
          exp_d = data_q.pop_front();
          check("pair_data", color_data, exp_d);
        end
        if (strobe_idx == 0) begin
          first_strobe_cyc = cyc;
        end else if (strict_period) begin
          check("period", 256'(cyc - last_strobe_cyc), 256'(4));
        end else begin
          check("period_min", 256'((cyc - last_strobe_cyc) >= 4), 256'(1));
        end
        snap_x          = tile_x;
        snap_y          = tile_y;
        snap_row        = tile_row;
        snap_data       = color_data;
        hold_pending    = 1'b1;
        last_strobe_cyc = cyc;
        strobe_idx++;
      end else if (hold_pending) begin
        check("hold_x", 256'(tile_x), 256'(snap_x));
        check("hold_y", 256'(tile_y), 256'(snap_y));
        check("hold_row", 256'(tile_row), 256'(snap_row));
        check("hold_data", color_data, snap_data);
        hold_pending = 1'b0;
      end
      if (frame_done) begin
        frame_done_cnt++;
        check("done_busy", 256'(busy), 256'(0));
        check("done_count", 256'(strobe_idx), 256'(9600));
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b0;
    row_valid   = 1'b0;
    row_data    = '0;
    clear_pair  = {32{8'hA5}};
`ifdef WB_CLEAR_EN
    clear_start = 1'b0;
    clear_color = 8'h00;
`endif
    reset_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 256'(row_ready), 256'(0));
    check("rst_done", 256'(render_done), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_fdone", 256'(frame_done), 256'(0));
    check("rst_coords", 256'({tile_x, tile_y, tile_row}), 256'(0));
    check("rst_data", color_data, 256'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;

    // Full frame with rows always valid, plus an ignored frame_start at pair 100.
    strict_period = 1'b1;
    drive_mode    = 0;
    pulse_start();
    wait_strobes(1, 20);
    check("start_to_strobe", 256'(first_strobe_cyc - start_cyc), 256'(3));
    check("busy_running", 256'(busy), 256'(1));
    wait_strobes(100, 1000);
    pulse_start();
    wait_done(45000);
    repeat (3) @(negedge clk);
    check("frames", 256'(frame_done_cnt), 256'(1));
    check("strobes", 256'(strobe_idx), 256'(9600));
    check("idle_busy", 256'(busy), 256'(0));

    // Random row_valid, then a one-cycle reset with half a pair captured.
    reset_model();
    strict_period = 1'b0;
    drive_mode    = 1;
    pulse_start();
    wait_strobes(40, 2000);
    begin
      int k = 0;
      @(posedge clk);
      while (!half && k < 200) begin
        @(posedge clk);
        k++;
      end
      if (!half) check("half_timeout", 256'(0), 256'(1));
    end
    #1 reset_n = 1'b0;
    drive_mode = 2;
    @(posedge clk);
    #1 reset_n = 1'b1;
    reset_model();
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_done", 256'(render_done), 256'(0));
      check("rst_mid_busy", 256'(busy), 256'(0));
      check("rst_mid_ready", 256'(row_ready), 256'(0));
      check("rst_mid_coords", 256'({tile_x, tile_y, tile_row}), 256'(0));
    end
    check("rst_mid_data", color_data, 256'(0));
    check("rst_mid_strobes", 256'(strobe_idx), 256'(0));

    strict_period = 1'b1;
    drive_mode    = 0;
    pulse_start();
    wait_strobes(16, 200);
    check("restart_latency", 256'(first_strobe_cyc - start_cyc), 256'(3));

`ifdef WB_CLEAR_EN
    // Clear frame: rows offered but never consumed, every pair the clear color.
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    reset_model();
    drive_mode  = 1;
    clear_color = 8'hA5;
    clear_run   = 1'b1;
    @(posedge clk);
    #1 clear_start = 1'b1;
    @(posedge clk);
    #1 clear_start = 1'b0;
    clear_color = 8'h3C;
    wait_done(45000);
    @(negedge clk);
    check("clr_strobes", 256'(strobe_idx), 256'(9600));
    check("clr_sb_untouched", 256'(data_q.size()), 256'(0));
    clear_run = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
